// File: rtl/demux_1to5.sv
// One-to-five demultiplexer. Each output channel is a one-word EMPTY/FULL buffer with a valid/ack handshake.
// The optional saturating invalid-select drop counter (err_cnt) is built only when DEMUX_ERR_CNT_EN is defined.
module demux_1to5 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [2:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [4:0]       out_valid,
   input  logic [4:0]       out_ack,
`ifdef DEMUX_ERR_CNT_EN
   output logic             sel_err,
   output logic [7:0]       err_cnt
`else
   output logic             sel_err
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chanState_t;

   chanState_t       r_state [5];
   logic [WIDTH-1:0] r_data  [5];
   logic             r_selErr;

   logic [4:0] w_selOneHot;
   logic [4:0] w_full;
   logic [4:0] w_write;
   logic       w_selValid;
   logic       w_ready;
   logic       w_xfer;
   logic       w_drop;

   always_comb begin
      w_selOneHot = '0;
      w_full      = '0;
      for (int k = 0; k < 5; k++) begin
         w_selOneHot[k] = (in_sel == 3'(k));
         w_full[k]      = (r_state[k] == FULL);
      end
   end

   // A full channel can still accept when its consumer drains it in the same cycle.
   assign w_selValid = |w_selOneHot;
   assign w_ready    = w_selValid ? |(w_selOneHot & (~w_full | out_ack)) : 1'b1;
   assign w_xfer     = in_valid & w_ready;
   assign w_write    = w_selOneHot & {5{w_xfer}};
   assign w_drop     = w_xfer & ~w_selValid;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 5; k++) begin
            r_state[k] <= EMPTY;
            r_data[k]  <= '0;
         end
         r_selErr <= 1'b0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (w_write[k]) begin
               r_state[k] <= FULL;
               r_data[k]  <= in_data;
            end else if (out_ack[k]) begin
               r_state[k] <= EMPTY;
            end
         end
         r_selErr <= w_drop;
      end
   end

`ifdef DEMUX_ERR_CNT_EN
   logic [7:0] r_errCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_errCnt <= '0;
      end else if (w_drop && (r_errCnt != 8'hFF)) begin
         r_errCnt <= r_errCnt + 8'd1;
      end
   end

   assign err_cnt = r_errCnt;
`endif

   assign in_ready  = w_ready;
   assign out_valid = w_full;
   assign out1      = r_data[0];
   assign out2      = r_data[1];
   assign out3      = r_data[2];
   assign out4      = r_data[3];
   assign out5      = r_data[4];
   assign sel_err   = r_selErr;

endmodule
